// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM controller.
// Optional macro SRAM_ARB_FIXED_PRIO_EN: port 0 always wins simultaneous requests.
module sram_arbiter #(
   parameter int ADDR_W = 21
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r1_req,
   input  logic              r0_we,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic signed [15:0] r0_wdata,
   input  logic signed [15:0] r1_wdata,
   output logic              r0_ack,
   output logic              r1_ack,
   output logic [15:0]       rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_din,
   output logic              sram_wr,
   output logic              sram_rd,
   input  logic              sram_ready,
   input  logic [15:0]       sram_dout,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                gnt_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [15:0]         din_q;
   logic [15:0]         rdata_q;
   logic                ack0_q, ack1_q;
   logic                start, done, sel;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   always_comb begin
      sel = ~r0_req;
   end
`else
   logic last_q;

   // Round-robin: on a tie the port not granted last wins.
   always_comb begin
      sel = (r0_req & r1_req) ? ~last_q : ~r0_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else if (start) begin
         last_q <= sel;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (sram_ready && (r0_req || r1_req)) begin
               start   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE:     state_d = WAIT_BUSY;
         WAIT_BUSY: if (!sram_ready) state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (sram_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ack0_q  <= done & ~gnt_q;
         ack1_q  <= done & gnt_q;
         if (start) begin
            gnt_q  <= sel;
            we_q   <= sel ? r1_we : r0_we;
            addr_q <= sel ? r1_addr : r0_addr;
            din_q  <= sel ? r1_wdata : r0_wdata;
         end
         // rdata only changes when a read completes.
         if (done && !we_q) begin
            rdata_q <= sram_dout;
         end
      end
   end

   assign sram_wr     = (state_q == ISSUE) &  we_q;
   assign sram_rd     = (state_q == ISSUE) & ~we_q;
   assign busy        = (state_q != IDLE);
   assign sram_addr   = addr_q;
   assign sram_din    = din_q;
   assign rdata       = rdata_q;
   assign r0_ack      = ack0_q;
   assign r1_ack      = ack1_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two-cycle SRAM controller model plus a transaction-level
// reference (memory array, round-robin grant rule, held read data).
module tb_sram_arbiter;

   localparam int ADDR_W = 21;

   logic              clk = 1'b0;
   logic              reset;
   logic              r0_req, r1_req, r0_we, r1_we;
   logic [ADDR_W-1:0] r0_addr, r1_addr;
   logic [15:0]       r0_wdata, r1_wdata;
   logic              r0_ack, r1_ack, busy, sram_wr, sram_rd, sram_ready;
   logic [15:0]       rdata, sram_din, sram_dout;
   logic [ADDR_W-1:0] sram_addr;
   logic [1:0]        dbg_state;

   sram_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
      .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
      .r0_ack(r0_ack), .r1_ack(r1_ack), .rdata(rdata), .busy(busy),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_wr(sram_wr), .sram_rd(sram_rd),
      .sram_ready(sram_ready), .sram_dout(sram_dout), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // Controller environment: accepts a strobe when idle, busy for two cycles.
   logic [1:0]  cnt;
   logic        hold_low;
   logic [15:0] ctrl_mem [0:31];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 2'd0;
         sram_dout <= 16'h0;
         for (int i = 0; i < 32; i++) ctrl_mem[i] <= 16'(i * 16'h0101);
      end else if (cnt != 2'd0) begin
         cnt <= cnt - 2'd1;
      end else if (sram_wr || sram_rd) begin
         cnt <= 2'd2;
         if (sram_wr) ctrl_mem[sram_addr[4:0]] <= sram_din;
         else sram_dout <= ctrl_mem[sram_addr[4:0]];
      end
   end
   assign sram_ready = (cnt == 2'd0) && !hold_low;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("one_ack", 32'(r0_ack & r1_ack), 32'd0);
         check("wr_rd_excl", 32'(sram_wr & sram_rd), 32'd0);
      end
   end

   // Requester drive state and reference model.
   logic              p_req [2];
   logic              p_we [2];
   logic [ADDR_W-1:0] p_addr [2];
   logic [15:0]       p_din [2];
   logic [15:0]       model_mem [0:31];
   logic [15:0]       exp_rdata;
   logic [15:0]       exp_q [$];
   int                model_last;

   assign r0_req = p_req[0];   assign r1_req = p_req[1];
   assign r0_we = p_we[0];     assign r1_we = p_we[1];
   assign r0_addr = p_addr[0]; assign r1_addr = p_addr[1];
   assign r0_wdata = p_din[0]; assign r1_wdata = p_din[1];

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_mem[i] = 16'(i * 16'h0101);
      exp_rdata = 16'h0;
      model_last = 1;
   endtask

   task automatic launch(input int p, input bit we, input logic [4:0] a, input logic [15:0] d);
      p_req[p] = 1'b1;
      p_we[p] = we;
      p_addr[p] = ADDR_W'(a);
      p_din[p] = d;
   endtask

   function automatic int winner();
`ifdef SRAM_ARB_FIXED_PRIO_EN
      return p_req[0] ? 0 : 1;
`else
      if (p_req[0] && p_req[1]) return (model_last == 0) ? 1 : 0;
      return p_req[0] ? 0 : 1;
`endif
   endfunction

   // Called with requests already presented and the DUT idle; expects ack 5 edges later.
   task automatic run_one(input bit keep);
      int w, got;
      logic e_we;
      logic [4:0] e_a;
      logic [15:0] e_d;
      w = winner();
      e_we = p_we[w];
      e_a = p_addr[w][4:0];
      e_d = p_din[w];
      if (!e_we) exp_q.push_back(model_mem[e_a]);
      got = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            check("issue_wr", 32'(sram_wr), 32'(e_we));
            check("issue_rd", 32'(sram_rd), 32'(!e_we));
            check("issue_addr", 32'(sram_addr), 32'(e_a));
            if (e_we) check("issue_din", 32'(sram_din), 32'(e_d));
         end
         if (r0_ack || r1_ack) begin
            got = c;
            break;
         end
      end
      if (got == 0) check("ack_timeout", 32'd0, 32'd1);
      check("ack_latency", 32'(got), 32'd5);
      check("ack_port0", 32'(r0_ack), 32'(w == 0));
      check("ack_port1", 32'(r1_ack), 32'(w == 1));
      if (e_we) model_mem[e_a] = e_d;
      else exp_rdata = exp_q.pop_front();
      check("rdata", 32'(rdata), 32'(exp_rdata));
      check("busy_ack", 32'(busy), 32'd0);
      model_last = w;
      if (!keep) p_req[w] = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      hold_low = 1'b0;
      for (int i = 0; i < 2; i++) begin
         p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_din[i] = '0;
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_din", 32'(sram_din), 32'd0);
      check("rst_strobe", 32'(sram_wr | sram_rd), 32'd0);
      check("rst_ack", 32'(r0_ack | r1_ack), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed write then read-back through the other port.
      launch(0, 1'b1, 5'h10, 16'h1234);
      run_one(1'b0);
      launch(1, 1'b0, 5'h10, 16'h0);
      run_one(1'b0);
      check("rd_back", 32'(rdata), 32'h1234);

      // Both requesters held high across four transfers.
      launch(0, 1'b1, 5'h02, 16'hA5A5);
      launch(1, 1'b1, 5'h03, 16'h5A5A);
      repeat (4) run_one(1'b1);
      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
      @(posedge clk);
      #1;

      // Reset during WAIT_DONE of a read.
      launch(1, 1'b0, 5'h02, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      check("pre_abort_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      p_req[1] = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rdata", 32'(rdata), 32'd0);
      check("abort_addr", 32'(sram_addr), 32'd0);
      model_reset();
      repeat (3) begin
         @(posedge clk);
         #1;
         check("abort_noack", 32'(r0_ack | r1_ack), 32'd0);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      launch(1, 1'b0, 5'h05, 16'h0);
      run_one(1'b0);

      // Controller not ready: no issue until ready returns.
      hold_low = 1'b1;
      launch(0, 1'b1, 5'h07, 16'hBEEF);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("hold_busy", 32'(busy), 32'd0);
         check("hold_strobe", 32'(sram_wr | sram_rd), 32'd0);
      end
      hold_low = 1'b0;
      run_one(1'b0);

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!p_req[p] && $urandom_range(0, 1) == 1)
               launch(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
         end
         if (!p_req[0] && !p_req[1])
            launch(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 16'($urandom));
         run_one(1'b0);
      end
      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
